// File: rtl/issue_if.sv
// Decode/execute boundary bundle for the dual-issue scheduler.
// master: decode/hazard-source side (drives pipeline status, receives controls).
// slave:  issue_ctrl.
interface issue_if;
  logic       validD1, validD2;
  logic [4:0] rs1D1, rs2D1, rs1D2, rs2D2;
  logic [4:0] rdD1;
  logic       reg_writeD1;
  logic       memD1, memD2;
  logic       branchD1;
  logic [4:0] rdE1, rdE2, rdM1, rdM2;
  logic       reg_writeE1, reg_writeE2, reg_writeM1, reg_writeM2;
  logic [2:0] mem_loadE1, mem_loadE2, mem_loadM1, mem_loadM2;
  logic       redirectE;
  logic       stallF, stallD;
  logic       flushD, flushE;
  logic [1:0] issue_mask;
  logic [31:0] perf_stall, perf_split;

  modport master (
    output validD1, validD2, rs1D1, rs2D1, rs1D2, rs2D2, rdD1, reg_writeD1,
           memD1, memD2, branchD1, rdE1, rdE2, rdM1, rdM2,
           reg_writeE1, reg_writeE2, reg_writeM1, reg_writeM2,
           mem_loadE1, mem_loadE2, mem_loadM1, mem_loadM2, redirectE,
    input  stallF, stallD, flushD, flushE, issue_mask, perf_stall, perf_split
  );

  modport slave (
    input  validD1, validD2, rs1D1, rs2D1, rs1D2, rs2D2, rdD1, reg_writeD1,
           memD1, memD2, branchD1, rdE1, rdE2, rdM1, rdM2,
           reg_writeE1, reg_writeE2, reg_writeM1, reg_writeM2,
           mem_loadE1, mem_loadE2, mem_loadM1, mem_loadM2, redirectE,
    output stallF, stallD, flushD, flushE, issue_mask, perf_stall, perf_split
  );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler and load-use hazard controller (decode/execute boundary).
// Optional feature macro: ISSUE_PERF_EN enables the perf_stall/perf_split counters;
// without it both counter outputs are tied to 0 and no counter flops exist.
//
// state | meaning
// PAIR  | decode pair not yet issued; may issue together, split, or stall
// HALF  | slot 1 already issued, slot 2 pending (D held)
module issue_ctrl (
  input  logic   clk,
  input  logic   rst,
  issue_if.slave bus
);

  typedef enum logic {PAIR = 1'b0, HALF = 1'b1} state_t;

  state_t state_q, state_d;

  logic [3:0]      ld_v;
  logic [3:0][4:0] rd_x;
  logic            hz1, hz2, intra, can_pair;

  // A source is hazardous if a load in E or M (either lane) is about to write it;
  // forwarding never supplies a load result from M, so these must wait.
  function automatic logic haz(input logic [4:0] s, input logic [3:0] v,
                               input logic [3:0][4:0] rd);
    haz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (s != 5'd0 && v[k] && s == rd[k]) haz = 1'b1;
    end
  endfunction

  assign ld_v = {bus.reg_writeM2 & (|bus.mem_loadM2),
                 bus.reg_writeM1 & (|bus.mem_loadM1),
                 bus.reg_writeE2 & (|bus.mem_loadE2),
                 bus.reg_writeE1 & (|bus.mem_loadE1)};
  assign rd_x = {bus.rdM2, bus.rdM1, bus.rdE2, bus.rdE1};

  assign hz1   = haz(bus.rs1D1, ld_v, rd_x) | haz(bus.rs2D1, ld_v, rd_x);
  assign hz2   = haz(bus.rs1D2, ld_v, rd_x) | haz(bus.rs2D2, ld_v, rd_x);
  assign intra = bus.reg_writeD1 & (bus.rdD1 != 5'd0) &
                 ((bus.rs1D2 == bus.rdD1) | (bus.rs2D2 == bus.rdD1));
  assign can_pair = bus.validD2 & ~hz2 & ~intra & ~(bus.memD1 & bus.memD2) & ~bus.branchD1;

  // State register; reset abandons any pending slot 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PAIR;
    else     state_q <= state_d;
  end

  // Issue decision: redirect wins, then per-state hazard/split logic; all outputs
  // are forced quiet while reset is held.
  always_comb begin
    state_d        = state_q;
    bus.stallF     = 1'b0;
    bus.stallD     = 1'b0;
    bus.flushD     = 1'b0;
    bus.flushE     = 1'b0;
    bus.issue_mask = 2'b00;
    if (rst) begin
      state_d = PAIR;
    end else if (bus.redirectE) begin
      bus.flushD = 1'b1;
      bus.flushE = 1'b1;
      state_d    = PAIR;
    end else begin
      case (state_q)
        PAIR: begin
          if (bus.validD1 && hz1) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
          end else if (can_pair) begin
            bus.issue_mask = 2'b11;
          end else if (bus.validD2) begin
            bus.issue_mask = 2'b01;
            bus.stallF     = 1'b1;
            bus.stallD     = 1'b1;
            state_d        = HALF;
          end else begin
            bus.issue_mask = {1'b0, bus.validD1};
          end
        end
        HALF: begin
          if (hz2) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
          end else begin
            bus.issue_mask = 2'b10;
            state_d        = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
  end

`ifdef ISSUE_PERF_EN
  logic [31:0] perf_stall_q, perf_split_q;
  logic        stall_evt, split_evt;

  // Load-use stall is the only stall with an empty issue mask; redirect cycles
  // never stall, so they are excluded automatically.
  assign stall_evt = bus.stallD & (bus.issue_mask == 2'b00);
  assign split_evt = ~rst & ~bus.redirectE & (state_q == PAIR) & (state_d == HALF);

  // Wrapping event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_split_q <= 32'd0;
    end else begin
      if (stall_evt) perf_stall_q <= perf_stall_q + 32'd1;
      if (split_evt) perf_split_q <= perf_split_q + 32'd1;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_split = perf_split_q;
`else
  assign bus.perf_stall = 32'd0;
  assign bus.perf_split = 32'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl. Counter expectations follow
// ISSUE_PERF_EN (zero when the counters are compiled out).
module tb_issue_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  issue_if bus ();

  issue_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {stallF, stallD, flushD, flushE}
  function automatic logic [3:0] ctl();
    return {bus.stallF, bus.stallD, bus.flushD, bus.flushE};
  endfunction

  task automatic clear_in();
    bus.validD1 = 0; bus.validD2 = 0;
    bus.rs1D1 = 0; bus.rs2D1 = 0; bus.rs1D2 = 0; bus.rs2D2 = 0;
    bus.rdD1 = 0; bus.reg_writeD1 = 0;
    bus.memD1 = 0; bus.memD2 = 0; bus.branchD1 = 0;
    bus.rdE1 = 0; bus.rdE2 = 0; bus.rdM1 = 0; bus.rdM2 = 0;
    bus.reg_writeE1 = 0; bus.reg_writeE2 = 0; bus.reg_writeM1 = 0; bus.reg_writeM2 = 0;
    bus.mem_loadE1 = 0; bus.mem_loadE2 = 0; bus.mem_loadM1 = 0; bus.mem_loadM2 = 0;
    bus.redirectE = 0;
  endtask

  // slot 1: x5 = x1 + x2 ; slot 2: x6 = x3 + x4
  task automatic pair_indep();
    bus.validD1 = 1; bus.validD2 = 1;
    bus.rs1D1 = 1; bus.rs2D1 = 2; bus.rdD1 = 5; bus.reg_writeD1 = 1;
    bus.rs1D2 = 3; bus.rs2D2 = 4;
    bus.memD1 = 0; bus.memD2 = 0; bus.branchD1 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_in();
    pair_indep();
    bus.redirectE = 1;
    #3;
    chk("rst_mask", 32'(bus.issue_mask), 32'd0);
    chk("rst_ctl", 32'(ctl()), 32'd0);
    chk("rst_pstall", bus.perf_stall, 32'd0);
    chk("rst_psplit", bus.perf_split, 32'd0);
    #9;
    rst = 1'b0;
    bus.redirectE = 0;
    #1;

    // Independent pair issues together, stays in PAIR.
    chk("indep_mask", 32'(bus.issue_mask), 32'd3);
    chk("indep_ctl", 32'(ctl()), 32'd0);
    cyc();
    chk("indep_mask2", 32'(bus.issue_mask), 32'd3);

    // Intra-pair dependence: split over two cycles.
    bus.rs1D2 = 5;
    #1;
    chk("dep_c1_mask", 32'(bus.issue_mask), 32'd1);
    chk("dep_c1_ctl", 32'(ctl()), 32'b1100);
    cyc();
    chk("dep_c2_mask", 32'(bus.issue_mask), 32'd2);
    chk("dep_c2_ctl", 32'(ctl()), 32'd0);
    chk("dep_psplit", bus.perf_split, pexp(1));
    pair_indep();
    cyc();
    chk("dep_back_pair", 32'(bus.issue_mask), 32'd3);

    // Load in E lane 2 feeding slot 1: two stall bubbles.
    bus.rdE2 = 7; bus.reg_writeE2 = 1; bus.mem_loadE2 = 3'b010;
    bus.rs1D1 = 7;
    #1;
    chk("ldE_mask", 32'(bus.issue_mask), 32'd0);
    chk("ldE_ctl", 32'(ctl()), 32'b1100);
    cyc();
    bus.rdE2 = 0; bus.reg_writeE2 = 0; bus.mem_loadE2 = 0;
    bus.rdM2 = 7; bus.reg_writeM2 = 1; bus.mem_loadM2 = 3'b010;
    #1;
    chk("ldM_mask", 32'(bus.issue_mask), 32'd0);
    chk("ldM_ctl", 32'(ctl()), 32'b1100);
    cyc();
    bus.rdM2 = 0; bus.reg_writeM2 = 0; bus.mem_loadM2 = 0;
    #1;
    chk("ld_resume", 32'(bus.issue_mask), 32'd3);
    chk("ld_pstall", bus.perf_stall, pexp(2));

    // Non-load writer in E must not stall.
    bus.rdE1 = 7; bus.reg_writeE1 = 1;
    #1;
    chk("alu_in_E", 32'(bus.issue_mask), 32'd3);
    bus.rdE1 = 0; bus.reg_writeE1 = 0;
    pair_indep();

    // Two memory ops in one pair: split.
    bus.memD1 = 1; bus.memD2 = 1;
    #1;
    chk("mem_c1_mask", 32'(bus.issue_mask), 32'd1);
    chk("mem_c1_ctl", 32'(ctl()), 32'b1100);
    cyc();
    chk("mem_c2_mask", 32'(bus.issue_mask), 32'd2);
    cyc();
    chk("mem_psplit", bus.perf_split, pexp(2));
    pair_indep();

    // x0 is never a hazard, even against a load "writing" x0.
    bus.rdM1 = 0; bus.reg_writeM1 = 1; bus.mem_loadM1 = 3'b100;
    bus.rs2D2 = 0;
    #1;
    chk("x0_nohaz", 32'(bus.issue_mask), 32'd3);
    bus.reg_writeM1 = 0; bus.mem_loadM1 = 0;
    pair_indep();

    // Redirect overrides a concurrent load-use hazard and is not counted.
    bus.rdE1 = 2; bus.reg_writeE1 = 1; bus.mem_loadE1 = 3'b010;
    bus.redirectE = 1;
    #1;
    chk("redir_hz_mask", 32'(bus.issue_mask), 32'd0);
    chk("redir_hz_ctl", 32'(ctl()), 32'b0011);
    cyc();
    chk("redir_hz_pstall", bus.perf_stall, pexp(2));
    bus.redirectE = 0;
    bus.rdE1 = 0; bus.reg_writeE1 = 0; bus.mem_loadE1 = 0;

    // Branch in slot 1 splits; redirect in HALF discards slot 2.
    bus.branchD1 = 1;
    #1;
    chk("br_c1_mask", 32'(bus.issue_mask), 32'd1);
    cyc();
    bus.redirectE = 1;
    #1;
    chk("half_redir_mask", 32'(bus.issue_mask), 32'd0);
    chk("half_redir_ctl", 32'(ctl()), 32'b0011);
    cyc();
    bus.redirectE = 0;
    pair_indep();
    #1;
    chk("half_redir_pair", 32'(bus.issue_mask), 32'd3);
    chk("half_redir_psplit", bus.perf_split, pexp(3));

    // Load hazard on slot 2 while in HALF.
    bus.rs1D2 = 5;
    #1;
    chk("hz2_split", 32'(bus.issue_mask), 32'd1);
    cyc();
    bus.rdE1 = 4; bus.reg_writeE1 = 1; bus.mem_loadE1 = 3'b001;
    bus.rs2D2 = 4;
    #1;
    chk("hz2_mask", 32'(bus.issue_mask), 32'd0);
    chk("hz2_ctl", 32'(ctl()), 32'b1100);
    cyc();
    bus.rdE1 = 0; bus.reg_writeE1 = 0; bus.mem_loadE1 = 0;
    #1;
    chk("hz2_release", 32'(bus.issue_mask), 32'd2);
    chk("hz2_pstall", bus.perf_stall, pexp(3));
    cyc();
    pair_indep();

    // Asynchronous reset while in HALF with nonzero counters.
    bus.rs1D2 = 5;
    #1;
    chk("ar_split", 32'(bus.issue_mask), 32'd1);
    cyc();
    chk("ar_psplit_pre", bus.perf_split, pexp(5));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mask", 32'(bus.issue_mask), 32'd0);
    chk("ar_ctl", 32'(ctl()), 32'd0);
    chk("ar_pstall", bus.perf_stall, 32'd0);
    chk("ar_psplit", bus.perf_split, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    // Same dependent pair now seen from PAIR: splits again instead of issuing slot 2.
    chk("ar_post_mask", 32'(bus.issue_mask), 32'd1);
    chk("ar_post_ctl", 32'(ctl()), 32'b1100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
